// File: rtl/dbg_inst_gen.sv
// Debug abstract-command instruction generator: turns register/memory access
// commands into RV32I/Zicsr program-buffer words and waits for the core to finish.
module dbg_inst_gen #(
    parameter logic [31:0] PBUF_BASE     = 32'h0000_0800,
    parameter logic [11:0] CSR_DSCRATCH0 = 12'h7B2,
    parameter logic [11:0] CSR_DSCRATCH1 = 12'h7B3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_type_i,
    input  logic [4:0]  cmd_regno_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        exec_done_i,
    input  logic        exec_err_i,
    output logic        busy_o,
    output logic        cmd_done_o,
    output logic        cmd_err_o
);

    localparam int unsigned IDX_W = 3;

    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [4:0]  X0        = 5'd0;
    localparam logic [4:0]  X8        = 5'd8;
    localparam logic [4:0]  X9        = 5'd9;
    localparam logic [31:0] LW_X8     = 32'h0004_2403;
    localparam logic [31:0] SW_X9     = 32'h0094_2023;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    localparam logic [1:0] T_REG_READ  = 2'd0;
    localparam logic [1:0] T_REG_WRITE = 2'd1;
    localparam logic [1:0] T_MEM_READ  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         type_q;
    logic [4:0]         regno_q;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;

    function automatic logic [31:0] csrrw(input logic [11:0] csr, input logic [4:0] rd,
                                          input logic [4:0] rs1);
        return {csr, rs1, 3'b001, rd, OP_SYSTEM};
    endfunction

    function automatic logic [31:0] csrrs_x0(input logic [11:0] csr, input logic [4:0] rd);
        return {csr, X0, 3'b010, rd, OP_SYSTEM};
    endfunction

    // Index of the terminating ebreak for each command type.
    function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] t);
        case (t)
            T_REG_READ, T_REG_WRITE: return IDX_W'(1);
            T_MEM_READ:              return IDX_W'(4);
            default:                 return IDX_W'(5);
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [1:0] t, input logic [4:0] r,
                                           input logic [IDX_W-1:0] i);
        logic [31:0] w;
        w = EBREAK;
        case (t)
            T_REG_READ:  if (i == IDX_W'(0)) w = csrrw(CSR_DSCRATCH0, X0, r);
            T_REG_WRITE: if (i == IDX_W'(0)) w = csrrs_x0(CSR_DSCRATCH0, r);
            T_MEM_READ: begin
                case (i)
                    IDX_W'(0), IDX_W'(3): w = csrrw(CSR_DSCRATCH1, X8, X8);
                    IDX_W'(1):            w = LW_X8;
                    IDX_W'(2):            w = csrrw(CSR_DSCRATCH0, X0, X8);
                    default:              w = EBREAK;
                endcase
            end
            default: begin
                case (i)
                    IDX_W'(0), IDX_W'(4): w = csrrw(CSR_DSCRATCH1, X8, X8);
                    IDX_W'(1), IDX_W'(3): w = csrrw(CSR_DSCRATCH0, X9, X9);
                    IDX_W'(2):            w = SW_X9;
                    default:              w = EBREAK;
                endcase
            end
        endcase
        return w;
    endfunction

    assign idx_nxt = idx + IDX_W'(1);

    // Sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            type_q       <= 2'd0;
            regno_q      <= 5'd0;
            idx          <= '0;
            cmd_ready_o  <= 1'b1;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'd0;
            inst_addr_o  <= 32'd0;
            busy_o       <= 1'b0;
            cmd_done_o   <= 1'b0;
            cmd_err_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        state        <= S_ISSUE;
                        type_q       <= cmd_type_i;
                        regno_q      <= cmd_regno_i;
                        idx          <= '0;
                        cmd_ready_o  <= 1'b0;
                        busy_o       <= 1'b1;
                        inst_valid_o <= 1'b1;
                        inst_o       <= encode(cmd_type_i, cmd_regno_i, IDX_W'(0));
                        inst_addr_o  <= PBUF_BASE;
                    end
                end
                S_ISSUE: begin
                    if (exec_err_i) begin
                        // Abort: remaining words are dropped.
                        state        <= S_DONE;
                        inst_valid_o <= 1'b0;
                        inst_o       <= 32'd0;
                        inst_addr_o  <= 32'd0;
                        cmd_done_o   <= 1'b1;
                        cmd_err_o    <= 1'b1;
                    end else if (inst_ready_i) begin
                        if (idx == last_idx(type_q)) begin
                            state        <= S_WAIT;
                            inst_valid_o <= 1'b0;
                            inst_o       <= 32'd0;
                            inst_addr_o  <= 32'd0;
                        end else begin
                            idx         <= idx_nxt;
                            inst_o      <= encode(type_q, regno_q, idx_nxt);
                            inst_addr_o <= PBUF_BASE + 32'({idx_nxt, 2'b00});
                        end
                    end
                end
                S_WAIT: begin
                    if (exec_err_i || exec_done_i) begin
                        state      <= S_DONE;
                        cmd_done_o <= 1'b1;
                        cmd_err_o  <= exec_err_i;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    cmd_done_o  <= 1'b0;
                    cmd_err_o   <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    idx         <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/dbg_inst_gen.md
# dbg_inst_gen

Debug abstract-command instruction generator. It encodes register-access and memory-access abstract commands into RV32I/Zicsr instruction sequences. It streams those words, with program-buffer addresses, into the fetch/if_id path through a valid/ready handshake, then waits for the core to report completion. It is the instruction producer on the decoder's input side. Every word it emits must decode as a legal CSR, load, store or `ebreak` instruction.

## Interface
Parameters:
- `PBUF_BASE`, 32'h0000_0800, address reported for sequence word 0; word n is at `PBUF_BASE + 4*n`.
- `CSR_DSCRATCH0`, 12'h7B2, data-exchange CSR.
- `CSR_DSCRATCH1`, 12'h7B3, address/save CSR.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: command accepted when both valid and ready are high.
- `cmd_type_i` in 2: command type. 0 = REG_READ, 1 = REG_WRITE, 2 = MEM_READ, 3 = MEM_WRITE.
- `cmd_regno_i` in 5: GPR number. Used only by REG_READ and REG_WRITE.
- `inst_valid_o` out 1: instruction word offered.
- `inst_ready_i` in 1: fetch path accepts the word.
- `inst_o` out 32: encoded instruction.
- `inst_addr_o` out 32: program-buffer address of `inst_o`.
- `exec_done_i` in 1: core retired the terminating `ebreak`.
- `exec_err_i` in 1: core took an exception while running the sequence.
- `busy_o` out 1: a command is in progress.
- `cmd_done_o` out 1: one-cycle completion pulse.
- `cmd_err_o` out 1: error flag. Valid while `cmd_done_o` is high; 0 otherwise.

## Operation
Encoding rules (opcode SYSTEM = 7'b1110011):
- csrrw rd,csr,rs1 = {csr, rs1, 3'b001, rd, 7'b1110011}.
- csrrs rd,csr,x0 = {csr, 5'd0, 3'b010, rd, 7'b1110011}.
- lw x8,0(x8) = 32'h0004_2403.
- sw x9,0(x8) = 32'h0094_2023.
- ebreak = 32'h0010_0073.

Sequences, where D0 = `CSR_DSCRATCH0`, D1 = `CSR_DSCRATCH1` and r = latched regno:
- REG_READ (2 words): csrrw x0,D0,r ; ebreak.
- REG_WRITE (2 words): csrrs r,D0,x0 ; ebreak.
- MEM_READ (5 words): csrrw x8,D1,x8 ; lw x8,0(x8) ; csrrw x0,D0,x8 ; csrrw x8,D1,x8 ; ebreak.
- MEM_WRITE (6 words): csrrw x8,D1,x8 ; csrrw x9,D0,x9 ; sw x9,0(x8) ; csrrw x9,D0,x9 ; csrrw x8,D1,x8 ; ebreak.

FSM states:
- IDLE: `cmd_ready_o`=1. On accept, latch type and regno, set idx=0, go to ISSUE.
- ISSUE: `inst_valid_o`=1, with `inst_o`/`inst_addr_o` taken from the latched type and idx.
  - On `inst_ready_i`, idx increments.
  - On acceptance of the last word, go to WAIT.
  - If `exec_err_i`=1, drop the remaining words (valid deasserts next cycle), latch err=1, go to DONE.
  - `exec_done_i` is ignored in ISSUE.
- WAIT: no valid. `exec_err_i` latches err=1 and goes to DONE. `exec_done_i` alone latches err=0 and goes to DONE. If both are high, err wins.
- DONE: `cmd_done_o`=1 and `cmd_err_o`=latched err for exactly one cycle, then go to IDLE.

Other rules:
- idx is 3 bits and never exceeds length−1. `inst_addr_o` = `PBUF_BASE + {idx, 2'b00}` (32-bit add, wraps modulo 2^32).
- regno 0 is legal: REG_WRITE x0 emits csrrs x0,D0,x0.
- `busy_o` = (state != IDLE).

## Timing
- Reset: state IDLE, idx 0, `cmd_ready_o`=1, `inst_valid_o`=0, `inst_o`=0, `inst_addr_o`=0, `busy_o`=0, `cmd_done_o`=0, `cmd_err_o`=0. `inst_o`/`inst_addr_o` are 0 whenever valid is low.
- Reset asserted mid-sequence returns to IDLE on the next edge with no `cmd_done_o` pulse.
- Command accepted at edge N: `inst_valid_o`=1 from cycle N+1. With `inst_ready_i` held high, one word is accepted per cycle.
- While `inst_valid_o`=1 and `inst_ready_i`=0: `inst_o` and `inst_addr_o` hold stable, and valid does not drop except on `exec_err_i`.
- Exec flag sampled at edge M in WAIT: `cmd_done_o` is high during cycle M+1. `cmd_ready_o` is 1 from cycle M+2.
- Minimum command-to-done latency is length + 2 cycles with immediate ready/done.
- Outputs are registered. There is no combinational path from `inst_ready_i` to `inst_valid_o`.

## Test plan
- REG_READ regno=5, ready high, then `exec_done_i` → words 0x7B229073 @0x800, 0x00100073 @0x804; `cmd_done_o`=1, `cmd_err_o`=0.
- REG_WRITE regno=10 → 0x7B202573, 0x00100073.
- MEM_READ with random `inst_ready_i` stalls → 0x7B341473, 0x00042403, 0x7B241073, 0x7B341473, 0x00100073 at 0x800–0x810; each word holds stable through its stall.
- MEM_WRITE → 0x7B341473, 0x7B2494F3, 0x00942023, 0x7B2494F3, 0x7B341473, 0x00100073; `cmd_ready_o`=0 throughout.
- `exec_err_i` during ISSUE of word 2 → no further valid words; `cmd_done_o`=1, `cmd_err_o`=1.
- `exec_done_i` and `exec_err_i` asserted together in WAIT → `cmd_err_o`=1.
- `rst` asserted mid-sequence → all outputs at reset values, no done pulse, and the next command starts at 0x800.
